operand_entry: RTL

OPERAND_ENTRY -- requirements
Module: operand_entry

---
 rtl/alu_pkg.sv | 30 +++
 rtl/btn_debounce.sv | 60 ++++++
 rtl/operand_entry.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the operand-entry front end of the ALU stage:
// field encoding, operand/op widths and digit limits.
package alu_pkg;

   // Entry field currently being edited; the encoding is visible on the state port.
   typedef enum logic [1:0] {
      S_A    = 2'd0,
      S_B    = 2'd1,
      S_OP   = 2'd2,
      S_DONE = 2'd3
   } entry_state_e;

   localparam int OP_W       = 3;
   localparam int OPND_W     = 10;
   localparam int MAX_DIGITS = 3;
   localparam int DIGIT_MAX  = 9;
   localparam int DCNT_W     = 2;

   // Decimal shift-in: v*10 + d built from shifts so no multiplier is inferred.
   // Callers guarantee v <= 99 and d <= 9, so the result always fits in OPND_W bits.
   function automatic logic [OPND_W-1:0] times_ten_add(
      input logic [OPND_W-1:0] v,
      input logic [3:0]        d
   );
      logic [OPND_W-1:0] d_ext;
      d_ext = {{(OPND_W-4){1'b0}}, d};
      return (v << 3) + (v << 1) + d_ext;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchronizer, stable-level debouncer and
// rising-edge press pulse generator. All state clears on reset, so a button
// held through reset release must be seen stable-high for DB_CYCLES samples.
module btn_debounce #(
   parameter int DB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic press
);

   localparam int CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;

   // Next-state logic: count consecutive samples that disagree with the qualified level.
   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
         end else begin
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = '0;
      end
      press_d = level_d & ~level_q;
   end

   // State registers; press is registered so it is a clean one-cycle pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/operand_entry.sv
// Operand entry front end: collects two decimal operands (up to three digits
// each) and an operation code from switches and buttons, then presents them
// to the ALU stage as a committed operation.
module operand_entry
   import alu_pkg::*;
#(
   parameter int DB_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        sw_digit,
   input  logic [OP_W-1:0]   sw_op,
   input  logic              btn_digit,
   input  logic              btn_next,
   input  logic              btn_clr,
   output logic [OPND_W-1:0] a,
   output logic [OPND_W-1:0] b,
   output logic [OP_W-1:0]   op,
   output logic [1:0]        state,
   output logic              valid
);

   logic press_digit_s, press_next_s, press_clr_s;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_digit (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_digit),
      .press   (press_digit_s)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_next),
      .press   (press_next_s)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_clr),
      .press   (press_clr_s)
   );

   entry_state_e      state_q, state_d;
   logic [OPND_W-1:0] a_q, a_d;
   logic [OPND_W-1:0] b_q, b_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic              valid_q, valid_d;
   logic [DCNT_W-1:0] dcnt_q, dcnt_d;
   logic              digit_ok_s;

   // A digit is accepted only if it is decimal and the field still has room.
   always_comb begin
      digit_ok_s = (sw_digit <= 4'(DIGIT_MAX)) && (dcnt_q < DCNT_W'(MAX_DIGITS));
   end

   // Entry FSM next state; clr beats next beats digit when presses coincide.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      valid_d = valid_q;
      dcnt_d  = dcnt_q;
      if (press_clr_s) begin
         state_d = S_A;
         a_d     = '0;
         b_d     = '0;
         op_d    = '0;
         valid_d = 1'b0;
         dcnt_d  = '0;
      end else if (press_next_s) begin
         case (state_q)
            S_A: begin
               state_d = S_B;
               dcnt_d  = '0;
            end
            S_B: begin
               state_d = S_OP;
               dcnt_d  = '0;
            end
            S_OP: begin
               state_d = S_DONE;
               op_d    = sw_op;
               valid_d = 1'b1;
               dcnt_d  = '0;
            end
            S_DONE: begin
               state_d = S_A;
               a_d     = '0;
               b_d     = '0;
               op_d    = '0;
               valid_d = 1'b0;
               dcnt_d  = '0;
            end
            default: begin
               state_d = S_A;
               a_d     = '0;
               b_d     = '0;
               op_d    = '0;
               valid_d = 1'b0;
               dcnt_d  = '0;
            end
         endcase
      end else if (press_digit_s) begin
         case (state_q)
            S_A: begin
               if (digit_ok_s) begin
                  a_d    = times_ten_add(a_q, sw_digit);
                  dcnt_d = dcnt_q + DCNT_W'(1);
               end else begin
                  a_d    = a_q;
               end
            end
            S_B: begin
               if (digit_ok_s) begin
                  b_d    = times_ten_add(b_q, sw_digit);
                  dcnt_d = dcnt_q + DCNT_W'(1);
               end else begin
                  b_d    = b_q;
               end
            end
            default: begin
               dcnt_d = dcnt_q;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Entry registers; every output below comes straight from these flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         valid_q <= 1'b0;
         dcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         valid_q <= valid_d;
         dcnt_q  <= dcnt_d;
      end
   end

   assign a     = a_q;
   assign b     = b_q;
   assign op    = op_q;
   assign state = state_q;
   assign valid = valid_q;

endmodule
